// File: rtl/button_pulse_conditioner.sv
// Raw push-button to clean single-cycle strobe: 2-flop synchroniser, debounce counter, press/release FSM.
// Optional auto-repeat while held is enabled by defining BUTTON_AUTO_REPEAT_EN.
module button_pulse_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned DB_WIDTH        = 8,
  parameter int unsigned REPEAT_PERIOD   = 16
) (
  input  logic CLK,
  input  logic RESET,
  input  logic BTN_IN,
  output logic PULSE_OUT,
  output logic BTN_LEVEL
);

  typedef enum logic [1:0] {
    RELEASED     = 2'd0,
    PRESS_PEND   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_PEND = 2'd3
  } state_t;

  localparam logic [DB_WIDTH-1:0] DB_LIMIT = DB_WIDTH'(DEBOUNCE_CYCLES);
  localparam logic [DB_WIDTH-1:0] CNT_ONE  = DB_WIDTH'(1);

  // Both periods must fit the counter and be non-zero.
  if (DEBOUNCE_CYCLES == 0 || (DEBOUNCE_CYCLES >> DB_WIDTH) != 0 ||
      REPEAT_PERIOD == 0 || (REPEAT_PERIOD >> DB_WIDTH) != 0) begin : g_bad_cfg
    $error("button_pulse_conditioner: DEBOUNCE_CYCLES/REPEAT_PERIOD out of range for DB_WIDTH");
  end

`ifdef BUTTON_AUTO_REPEAT_EN
  localparam logic [DB_WIDTH-1:0] RPT_LIMIT = DB_WIDTH'(REPEAT_PERIOD - 1);
`endif

  logic                s1;
  logic                s2;
  state_t              state;
  logic [DB_WIDTH-1:0] cnt;

  // Two-flop synchroniser for the asynchronous button level.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= BTN_IN;
      s2 <= s1;
    end
  end

  // Press/release FSM; cnt is cleared on every state change so it never wraps.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state     <= RELEASED;
      cnt       <= '0;
      PULSE_OUT <= 1'b0;
      BTN_LEVEL <= 1'b0;
    end else begin
      PULSE_OUT <= 1'b0;
      case (state)
        RELEASED: begin
          if (s2) begin
            state <= PRESS_PEND;
            cnt   <= CNT_ONE;
          end else begin
            cnt   <= '0;
          end
        end
        PRESS_PEND: begin
          if (!s2) begin
            state <= RELEASED;
            cnt   <= '0;
          end else if (cnt == DB_LIMIT) begin
            state     <= PRESSED;
            cnt       <= '0;
            PULSE_OUT <= 1'b1;
            BTN_LEVEL <= 1'b1;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        PRESSED: begin
          if (!s2) begin
            state <= RELEASE_PEND;
            cnt   <= CNT_ONE;
          end
`ifdef BUTTON_AUTO_REPEAT_EN
          else if (cnt == RPT_LIMIT) begin
            PULSE_OUT <= 1'b1;
            cnt       <= '0;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
`endif
        end
        RELEASE_PEND: begin
          if (s2) begin
            state <= PRESSED;
            cnt   <= '0;
          end else if (cnt == DB_LIMIT) begin
            state     <= RELEASED;
            cnt       <= '0;
            BTN_LEVEL <= 1'b0;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        default: begin
          state     <= RELEASED;
          cnt       <= '0;
          BTN_LEVEL <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/button_pulse_conditioner.md
Name: button_pulse_conditioner

Overview:
- Conditions a raw asynchronous push-button into a clean, debounced, single-cycle strobe.
- Sits directly upstream of the generic counter: PULSE_OUT drives that counter's ENABLE, so each physical press advances the count by exactly one.
- Contains a 2-flop synchroniser, a debounce counter and a 4-state press/release FSM.

Parameters:
- DEBOUNCE_CYCLES, 4: consecutive stable clocks (at synchroniser output) needed to accept a level change; legal range 1..2^DB_WIDTH-1.
- DB_WIDTH, 8: width of the debounce counter.
- REPEAT_PERIOD, 16: clocks between auto-repeat strobes. Used only with BUTTON_AUTO_REPEAT_EN; legal range 1..2^DB_WIDTH-1.

Ports:
- CLK  input  1  system clock, all logic on its rising edge.
- RESET  input  1  asynchronous, active-low reset; 0 clears all state immediately.
- BTN_IN  input  1  raw button level, asynchronous, may bounce; 1 = pressed.
- PULSE_OUT  output  1  registered one-clock strobe per accepted press; drives the downstream counter's ENABLE.
- BTN_LEVEL  output  1  registered debounced button level.

Behaviour:
- Reset (RESET=0, asynchronous):
  - sync flops = 0, debounce counter = 0, FSM = RELEASED.
  - PULSE_OUT = 0, BTN_LEVEL = 0.
  - Asserting reset mid-press abandons the press: no pulse, and no pulse on release.
- Synchroniser: BTN_IN -> s1 -> s2. The FSM sees only s2, two clocks after BTN_IN is sampled.
- FSM states and transitions, with cnt = debounce counter (all registered):
  - RELEASED: s2=1 -> PRESS_PEND, cnt<=1. Otherwise stay, cnt<=0.
  - PRESS_PEND:
    - s2=0 -> RELEASED, cnt<=0 (bounce rejected, no pulse).
    - Else if cnt==DEBOUNCE_CYCLES -> PRESSED, cnt<=0, PULSE_OUT<=1.
    - Else cnt<=cnt+1.
  - PRESSED: s2=0 -> RELEASE_PEND, cnt<=1. Otherwise stay.
  - RELEASE_PEND:
    - s2=1 -> PRESSED, cnt<=0 (bounce rejected, no second pulse).
    - Else if cnt==DEBOUNCE_CYCLES -> RELEASED, cnt<=0.
    - Else cnt<=cnt+1.
- Outputs:
  - PULSE_OUT is high for exactly one clock, only on the PRESS_PEND->PRESSED transition, except for auto-repeat strobes when BUTTON_AUTO_REPEAT_EN is defined. It is 0 in all other cycles.
  - BTN_LEVEL is 1 while in PRESSED or RELEASE_PEND, 0 while in RELEASED or PRESS_PEND; it is registered alongside the state.
- Latency: BTN_IN first sampled high at edge k and held -> PULSE_OUT high from edge k+2+DEBOUNCE_CYCLES for one clock; BTN_LEVEL rises at the same edge.
- Release latency: BTN_LEVEL falls DEBOUNCE_CYCLES+2 edges after BTN_IN is first sampled low.
- Boundaries:
  - A high or low glitch shorter than DEBOUNCE_CYCLES clocks at s2 never changes state.
  - With DEBOUNCE_CYCLES=1, the minimum accepted press is 2 clocks at s2.
  - cnt never wraps: it is cleared on every state change and bounded by DEBOUNCE_CYCLES.
  - A button held indefinitely produces exactly one pulse (macro undefined).

Optional Feature:
- Macro: BUTTON_AUTO_REPEAT_EN.
- Defined:
  - In PRESSED, cnt counts up each clock.
  - When cnt==REPEAT_PERIOD-1, PULSE_OUT<=1 for one clock and cnt<=0.
  - The first repeat occurs REPEAT_PERIOD clocks after the initial pulse; repeats continue every REPEAT_PERIOD clocks until s2 leaves PRESSED.
  - Entering RELEASE_PEND stops repeats immediately.
  - Re-entering PRESSED from RELEASE_PEND restarts the repeat count from 0 and produces no immediate pulse.
- Undefined: no repeat logic is synthesised, REPEAT_PERIOD is unused, and a held button gives one pulse.

Test Plan:
- Reset check: RESET=0 with BTN_IN=1 toggling for 20 clocks -> PULSE_OUT=0 and BTN_LEVEL=0 throughout.
- Clean press (DEBOUNCE_CYCLES=4): BTN_IN 0->1 before edge 0, held 40 clocks -> PULSE_OUT=1 only between edges 6 and 7, BTN_LEVEL=1 from edge 6. With the downstream counter on ENABLE, COUNT goes 0->1.
- Bounce rejection: BTN_IN pattern 1,0,1,1,0,1 (one clock each), then 0 -> PULSE_OUT never 1, BTN_LEVEL stays 0.
- Release bounce: held press, then BTN_IN 0 for 2 clocks, 1 for 10 clocks, then 0 for 10 clocks -> exactly one PULSE_OUT; BTN_LEVEL falls 6 edges after the final low is sampled.
- Reset mid-operation: RESET driven low asynchronously while in PRESS_PEND (cnt=2), released 3 clocks later with BTN_IN still 1 -> no pulse before re-debounce; pulse occurs 6 edges after reset release.
- Auto-repeat (macro defined, REPEAT_PERIOD=16, DEBOUNCE_CYCLES=4): BTN_IN held 60 clocks from edge 0 -> PULSE_OUT at edges 6, 22, 38, 54, i.e. 4 pulses. Macro undefined, same stimulus -> 1 pulse at edge 6.
